// File: rtl/reversi_pkg.sv
// Shared constants for the Reversi move-resolution datapath: cell encoding,
// player bits, direction table, FSM states and opening position.
package reversi_pkg;

  localparam int BOARD_N = 8;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_WHITE = 2'b01;
  localparam logic [1:0] CELL_BLACK = 2'b10;

  localparam logic PLAYER_BLACK = 1'b1;
  localparam logic PLAYER_WHITE = 1'b0;

  // 4-bit two's-complement steps, entry d = direction d (N, NE, E, SE, S, SW, W, NW)
  localparam logic [7:0][3:0] DIR_DX = 32'hFFF0_1110;
  localparam logic [7:0][3:0] DIR_DY = 32'hF011_10FF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SCAN   = 3'd2,
    ST_FLIP   = 3'd3,
    ST_DONE   = 3'd4,
    ST_REJECT = 3'd5
  } fe_state_e;

  function automatic logic [1:0] player_cell(input logic p);
    return (p == PLAYER_BLACK) ? CELL_BLACK : CELL_WHITE;
  endfunction

  // Index = y*8+x: (3,3),(4,4) white; (4,3),(3,4) black.
  function automatic logic [1:0] opening_cell(input logic [5:0] idx);
    logic [1:0] c;
    case (idx)
      6'd27, 6'd36: c = CELL_WHITE;
      6'd28, 6'd35: c = CELL_BLACK;
      default:      c = CELL_EMPTY;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/board_regfile.sv
// 64x2-bit board store: one synchronous write port, asynchronous scan and
// display read ports, synchronous active-low reset to the opening position.
module board_regfile
  import reversi_pkg::*;
#(
  parameter int N = BOARD_N
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       we_i,
  input  logic [5:0] waddr_i,
  input  logic [1:0] wdata_i,
  input  logic [5:0] scan_addr_i,
  output logic [1:0] scan_data_o,
  input  logic [5:0] disp_addr_i,
  output logic [1:0] disp_data_o
);

  localparam int CELLS = N * N;

  logic [1:0] cells_q [CELLS];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < CELLS; i++) begin
        cells_q[i] <= opening_cell(6'(i));
      end
    end else if (we_i) begin
      cells_q[waddr_i] <= wdata_i;
    end
  end

  assign scan_data_o = cells_q[scan_addr_i];
  assign disp_data_o = cells_q[disp_addr_i];

endmodule

// File: rtl/flip_engine.sv
// Reversi move resolution: checks the target, scans eight directions one cell
// per cycle, flips bracketed discs one per cycle, then places the new disc.
module flip_engine
  import reversi_pkg::*;
#(
  parameter int N = BOARD_N
) (
  input  logic       clk,
  input  logic       resetn,
  // Handshake: a request transfers on a rising edge where move_valid and
  // move_ready are both high; move_valid seen while busy is dropped, not queued.
  input  logic       move_valid,
  input  logic [2:0] move_x,
  input  logic [2:0] move_y,
  input  logic       player,
  output logic       move_ready,
  output logic       turn_done,
  output logic       move_illegal,
  output logic [4:0] flip_count,
  input  logic [2:0] rd_x,
  input  logic [2:0] rd_y,
  output logic [1:0] rd_cell,
  output fe_state_e  dbg_state
);

  fe_state_e  state_q, state_d;
  logic [2:0] x_q, x_d;
  logic [2:0] y_q, y_d;
  logic       player_q, player_d;
  logic [2:0] dir_q, dir_d;
  logic [3:0] k_q, k_d;
  logic [3:0] run_q, run_d;
  logic [3:0] cx_q, cx_d;
  logic [3:0] cy_q, cy_d;
  logic [4:0] flip_count_q, flip_count_d;

  logic [5:0] scan_addr;
  logic [1:0] scan_cell;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [1:0] own_cell;
  logic [1:0] opp_cell;
  logic [3:0] dx;
  logic [3:0] dy;
  logic [2:0] dir_nx;
  logic       off_board;
  logic       dir_end;

  assign own_cell = player_cell(player_q);
  assign opp_cell = player_cell(~player_q);
  assign dx       = DIR_DX[dir_q];
  assign dy       = DIR_DY[dir_q];
  assign dir_nx   = dir_q + 3'd1;
  // Scan positions never stray more than one step past an edge (-1..8), so
  // bit 3 set means negative or 8: off-board in both cases, never wrapped.
  assign off_board = cx_q[3] | cy_q[3];
  assign scan_addr = (state_q == ST_CHECK) ? {y_q, x_q} : {cy_q[2:0], cx_q[2:0]};

  board_regfile #(.N(N)) u_board (
    .clk         (clk),
    .resetn      (resetn),
    .we_i        (wr_en),
    .waddr_i     (wr_addr),
    .wdata_i     (own_cell),
    .scan_addr_i (scan_addr),
    .scan_data_o (scan_cell),
    .disp_addr_i ({rd_y, rd_x}),
    .disp_data_o (rd_cell)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      player_q     <= 1'b0;
      dir_q        <= '0;
      k_q          <= 4'd1;
      run_q        <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      flip_count_q <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      player_q     <= player_d;
      dir_q        <= dir_d;
      k_q          <= k_d;
      run_q        <= run_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      flip_count_q <= flip_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    player_d     = player_q;
    dir_d        = dir_q;
    k_d          = k_q;
    run_d        = run_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    flip_count_d = flip_count_q;
    wr_en        = 1'b0;
    wr_addr      = {y_q, x_q};
    dir_end      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (move_valid) begin
          x_d          = move_x;
          y_d          = move_y;
          player_d     = player;
          flip_count_d = '0;
          dir_d        = '0;
          k_d          = 4'd1;
          state_d      = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (scan_cell != CELL_EMPTY) begin
          state_d = ST_REJECT;
        end else begin
          cx_d    = {1'b0, x_q} + DIR_DX[0];
          cy_d    = {1'b0, y_q} + DIR_DY[0];
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (off_board || scan_cell == CELL_EMPTY) begin
          dir_end = 1'b1;
        end else if (scan_cell == opp_cell) begin
          k_d  = k_q + 4'd1;
          cx_d = cx_q + dx;
          cy_d = cy_q + dy;
        end else if (k_q == 4'd1) begin
          dir_end = 1'b1;
        end else begin
          // Bracket found: rewind to k=1 and flip outward for k-1 cycles.
          run_d        = k_q - 4'd1;
          flip_count_d = flip_count_q + {1'b0, k_q - 4'd1};
          cx_d         = {1'b0, x_q} + dx;
          cy_d         = {1'b0, y_q} + dy;
          state_d      = ST_FLIP;
        end
      end
      ST_FLIP: begin
        wr_en   = 1'b1;
        wr_addr = {cy_q[2:0], cx_q[2:0]};
        cx_d    = cx_q + dx;
        cy_d    = cy_q + dy;
        run_d   = run_q - 4'd1;
        if (run_q == 4'd1) begin
          dir_end = 1'b1;
        end
      end
      ST_DONE: begin
        wr_en   = 1'b1;
        wr_addr = {y_q, x_q};
        state_d = ST_IDLE;
      end
      ST_REJECT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (dir_end) begin
      if (dir_q == 3'd7) begin
        state_d = (flip_count_q != '0) ? ST_DONE : ST_REJECT;
      end else begin
        dir_d   = dir_nx;
        k_d     = 4'd1;
        cx_d    = {1'b0, x_q} + DIR_DX[dir_nx];
        cy_d    = {1'b0, y_q} + DIR_DY[dir_nx];
        state_d = ST_SCAN;
      end
    end
  end

  assign move_ready   = (state_q == ST_IDLE);
  assign turn_done    = (state_q == ST_DONE);
  assign move_illegal = (state_q == ST_REJECT);
  assign flip_count   = flip_count_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_flip_engine.sv
// Bench for flip_engine: directed opening-position cases, reset during a flip,
// then randomized play checked against a board-level Reversi model.
module tb_flip_engine;
  import reversi_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       move_valid = 1'b0;
  logic [2:0] move_x = '0;
  logic [2:0] move_y = '0;
  logic       player = 1'b0;
  logic [2:0] rd_x = '0;
  logic [2:0] rd_y = '0;
  logic       move_ready;
  logic       turn_done;
  logic       move_illegal;
  logic [4:0] flip_count;
  logic [1:0] rd_cell;
  fe_state_e  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Model board: 0 empty, 1 white, 2 black; index y*8+x.
  int mb [64];
  int dxt [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int dyt [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
  logic [127:0] exp_q [$];

  flip_engine #(.N(8)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .move_valid   (move_valid),
    .move_x       (move_x),
    .move_y       (move_y),
    .player       (player),
    .move_ready   (move_ready),
    .turn_done    (turn_done),
    .move_illegal (move_illegal),
    .flip_count   (flip_count),
    .rd_x         (rd_x),
    .rd_y         (rd_y),
    .rd_cell      (rd_cell),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic void model_reset();
    for (int i = 0; i < 64; i++) mb[i] = 0;
    mb[3*8+3] = 1;
    mb[4*8+4] = 1;
    mb[3*8+4] = 2;
    mb[4*8+3] = 2;
  endfunction

  function automatic int cell_at(input int x, input int y);
    if (x < 0 || x > 7 || y < 0 || y > 7) return -1;
    return mb[y*8+x];
  endfunction

  function automatic logic [127:0] model_vec();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) v[2*i +: 2] = 2'(mb[i]);
    return v;
  endfunction

  // flips = discs this move would turn; lat = cycle of the DONE/REJECT pulse
  // counted from the accept edge (CHECK is cycle 1).
  function automatic void model_move(input int x, input int y, input bit p, input bit apply,
                                     output int flips, output int lat);
    int own, opp, k, cx, cy;
    own   = p ? 2 : 1;
    opp   = p ? 1 : 2;
    flips = 0;
    if (mb[y*8+x] != 0) begin
      lat = 2;
      return;
    end
    lat = 1;
    for (int d = 0; d < 8; d++) begin
      k  = 1;
      cx = x + dxt[d];
      cy = y + dyt[d];
      while (cell_at(cx, cy) == opp) begin
        k++;
        cx += dxt[d];
        cy += dyt[d];
      end
      lat += k;
      if (cell_at(cx, cy) == own && k >= 2) begin
        lat   += k - 1;
        flips += k - 1;
        if (apply) begin
          for (int j = 1; j < k; j++) mb[(y + j*dyt[d])*8 + x + j*dxt[d]] = own;
        end
      end
    end
    lat += 1;
    if (apply && flips > 0) mb[y*8+x] = own;
  endfunction

  // drivers
  task automatic do_reset();
    resetn = 1'b0;
    move_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();
    exp_q.delete();
  endtask

  task automatic read_board(output logic [127:0] v);
    v = '0;
    for (int i = 0; i < 64; i++) begin
      rd_x = 3'(i % 8);
      rd_y = 3'(i / 8);
      #1;
      v[2*i +: 2] = rd_cell;
    end
  endtask

  task automatic run_move(input int x, input int y, input bit p, input bit hold);
    int flips, lat, seen;
    logic [127:0] got;
    model_move(x, y, p, 1'b1, flips, lat);
    exp_q.push_back(model_vec());
    @(negedge clk);
    move_valid = 1'b1;
    move_x = 3'(x);
    move_y = 3'(y);
    player = p;
    @(posedge clk);
    seen = 0;
    for (int c = 1; c <= 60 && seen == 0; c++) begin
      @(negedge clk);
      player = 1'($urandom_range(0, 1));
      if (hold) begin
        move_x = 3'($urandom_range(0, 7));
        move_y = 3'($urandom_range(0, 7));
      end else begin
        move_valid = 1'b0;
      end
      if (c == 1) chk("ready_while_busy", 128'(move_ready), 128'(0));
      if (turn_done || move_illegal) begin
        seen = c;
        move_valid = 1'b0;
        chk("pulse_cycle", 128'(c), 128'(lat));
        chk("pulse_kind", 128'({turn_done, move_illegal}), (flips > 0) ? 128'(2) : 128'(1));
        chk("flip_count", 128'(flip_count), 128'(flips));
      end
    end
    if (seen == 0) begin
      move_valid = 1'b0;
      chk("pulse_timeout", 128'(seen), 128'(lat));
    end
    @(negedge clk);
    chk("pulse_one_cycle", 128'({turn_done, move_illegal}), 128'(0));
    chk("ready_after", 128'(move_ready), 128'(1));
    read_board(got);
    chk("board", got, exp_q.pop_front());
  endtask

  task automatic reset_mid_flip();
    logic [127:0] got;
    int pulses;
    do_reset();
    @(negedge clk);
    move_valid = 1'b1;
    move_x = 3'd2;
    move_y = 3'd3;
    player = PLAYER_BLACK;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      move_valid = 1'b0;
    end
    chk("state_in_flip", 128'(dbg_state), 128'(ST_FLIP));
    resetn = 1'b0;
    move_valid = 1'b1;
    @(negedge clk);
    chk("rst_ready", 128'(move_ready), 128'(1));
    chk("rst_pulses", 128'({turn_done, move_illegal}), 128'(0));
    chk("rst_state", 128'(dbg_state), 128'(ST_IDLE));
    chk("rst_flip_count", 128'(flip_count), 128'(0));
    read_board(got);
    chk("rst_board", got, model_vec());
    move_valid = 1'b0;
    resetn = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (turn_done || move_illegal) pulses++;
    end
    chk("no_pulse_after_rst", 128'(pulses), 128'(0));
  endtask

  task automatic random_phase(input int moves);
    bit p;
    int mv [$];
    int f, l, idx, passes;
    p = PLAYER_BLACK;
    passes = 0;
    for (int m = 0; m < moves; m++) begin
      mv.delete();
      for (int i = 0; i < 64; i++) begin
        model_move(i % 8, i / 8, p, 1'b0, f, l);
        if (f > 0) mv.push_back(i);
      end
      if (mv.size() == 0 || $urandom_range(0, 4) == 0) idx = $urandom_range(0, 63);
      else idx = mv[$urandom_range(0, mv.size() - 1)];
      run_move(idx % 8, idx / 8, p, 1'($urandom_range(0, 1)));
      if (mv.size() == 0) begin
        passes++;
        if (passes >= 2) begin
          do_reset();
          passes = 0;
        end
      end else begin
        passes = 0;
      end
      p = ~p;
    end
  endtask

  // main sequence + report
  initial begin
    logic [127:0] got;
    int nonempty;
    do_reset();
    @(negedge clk);
    chk("reset_ready", 128'(move_ready), 128'(1));
    chk("reset_turn_done", 128'(turn_done), 128'(0));
    chk("reset_illegal", 128'(move_illegal), 128'(0));
    chk("reset_flip_count", 128'(flip_count), 128'(0));
    chk("reset_state", 128'(dbg_state), 128'(ST_IDLE));
    read_board(got);
    chk("reset_board", got, model_vec());
    nonempty = 0;
    for (int i = 0; i < 64; i++) if (got[2*i +: 2] != 2'b00) nonempty++;
    chk("reset_nonempty", 128'(nonempty), 128'(4));

    run_move(3, 3, PLAYER_BLACK, 1'b0);
    run_move(0, 0, PLAYER_BLACK, 1'b0);
    run_move(2, 3, PLAYER_BLACK, 1'b1);
    run_move(2, 2, PLAYER_WHITE, 1'b0);

    reset_mid_flip();

    do_reset();
    random_phase(160);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
